// File: rtl/axi_common_types_pkg.sv
// Shared AXI interconnect types: write-arbiter state encoding, arbiter sizing
// and the round-robin winner function used by the per-slave arbiters.
package axi_common_types_pkg;

  localparam int AXI_LEN_WIDTH = 4;
  localparam int S0_ARB_NUM_M  = 4;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW   = 2'd1,
    WR_W    = 2'd2,
    WR_B    = 2'd3
  } wr_arb_state_e;

  // First requester found scanning upward from ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin picker: combinational winner from the pointer, pointer
// moves past the served requester when advance_i is strobed.
module rr_arbiter4
  import axi_common_types_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       advance_i,
  input  logic [1:0] served_i,
  output logic [1:0] pick_o
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  assign pick_o = rr_pick(req_i, ptr_q);
  assign ptr_d  = advance_i ? served_i + 2'd1 : ptr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/s0_wr_arbiter.sv
// Slave 0 write-path arbiter: one AW/W/B transaction at a time, round-robin
// across the masters, with a registered grant index for the payload muxes.
module s0_wr_arbiter
  import axi_common_types_pkg::*;
#(
  parameter int NUM_M = S0_ARB_NUM_M,
  parameter int LEN_W = AXI_LEN_WIDTH
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_M-1:0]       M_AWVALID,
  output logic [NUM_M-1:0]       M_AWREADY,
  input  logic [NUM_M*LEN_W-1:0] M_AWLEN,
  input  logic [NUM_M-1:0]       M_WVALID,
  input  logic [NUM_M-1:0]       M_WLAST,
  output logic [NUM_M-1:0]       M_WREADY,
  output logic [NUM_M-1:0]       M_BVALID,
  input  logic [NUM_M-1:0]       M_BREADY,
  output logic                   S0_AWVALID,
  input  logic                   S0_AWREADY,
  output logic                   S0_WVALID,
  output logic                   S0_WLAST,
  input  logic                   S0_WREADY,
  input  logic                   S0_BVALID,
  output logic                   S0_BREADY,
  output logic [1:0]             GRANT_IDX,
  output logic                   GRANT_VLD,
  output logic                   ERR_WLAST
);

  wr_arb_state_e    state_q;
  logic [1:0]       grant_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             err_q;

  logic [1:0]       pick;
  logic             aw_hs;
  logic             w_hs;
  logic             b_hs;
  logic             last_beat;
  logic [LEN_W-1:0] sel_awlen;

  rr_arbiter4 u_rr (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .req_i     (M_AWVALID),
    .advance_i (b_hs),
    .served_i  (grant_q),
    .pick_o    (pick)
  );

  assign sel_awlen = M_AWLEN[grant_q*LEN_W +: LEN_W];
  assign last_beat = (beat_cnt_q == len_q);
  assign aw_hs     = (state_q == WR_AW) && M_AWVALID[grant_q] && S0_AWREADY;
  assign w_hs      = (state_q == WR_W)  && M_WVALID[grant_q]  && S0_WREADY;
  assign b_hs      = (state_q == WR_B)  && S0_BVALID          && M_BREADY[grant_q];

  assign GRANT_IDX = grant_q;
  assign GRANT_VLD = (state_q != WR_IDLE);
  assign ERR_WLAST = err_q;

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    M_AWREADY  = '0;
    M_WREADY   = '0;
    M_BVALID   = '0;
    S0_AWVALID = 1'b0;
    S0_WVALID  = 1'b0;
    S0_WLAST   = 1'b0;
    S0_BREADY  = 1'b0;
    unique case (state_q)
      WR_AW: begin
        S0_AWVALID         = M_AWVALID[grant_q];
        M_AWREADY[grant_q] = S0_AWREADY;
      end
      WR_W: begin
        S0_WVALID         = M_WVALID[grant_q];
        S0_WLAST          = last_beat;
        M_WREADY[grant_q] = S0_WREADY;
      end
      WR_B: begin
        M_BVALID[grant_q] = S0_BVALID;
        S0_BREADY         = M_BREADY[grant_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= WR_IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        WR_IDLE: begin
          if (|M_AWVALID) begin
            grant_q <= pick;
            state_q <= WR_AW;
          end
        end
        WR_AW: begin
          if (aw_hs) begin
            len_q      <= sel_awlen;
            beat_cnt_q <= '0;
            state_q    <= WR_W;
          end
        end
        WR_W: begin
          if (w_hs) begin
            if (M_WLAST[grant_q] != last_beat) err_q <= 1'b1;
            // The burst ends on the AWLEN count, so the counter holds at the last beat.
            if (last_beat) state_q    <= WR_B;
            else           beat_cnt_q <= beat_cnt_q + LEN_W'(1);
          end
        end
        WR_B: begin
          if (b_hs) state_q <= WR_IDLE;
        end
        default: state_q <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s0_wr_arbiter.sv
// Directed bench for s0_wr_arbiter: behavioural masters and S0 slave, with a
// scoreboard of expected grants/burst lengths checked as transactions complete.
module tb_s0_wr_arbiter;

  logic        ACLK;
  logic        ARESET;
  logic [3:0]  M_AWVALID, M_AWREADY;
  logic [15:0] M_AWLEN;
  logic [3:0]  M_WVALID, M_WLAST, M_WREADY;
  logic [3:0]  M_BVALID, M_BREADY;
  logic        S0_AWVALID, S0_AWREADY;
  logic        S0_WVALID, S0_WLAST, S0_WREADY;
  logic        S0_BVALID, S0_BREADY;
  logic [1:0]  GRANT_IDX;
  logic        GRANT_VLD;
  logic        ERR_WLAST;

  s0_wr_arbiter dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .M_AWVALID  (M_AWVALID),
    .M_AWREADY  (M_AWREADY),
    .M_AWLEN    (M_AWLEN),
    .M_WVALID   (M_WVALID),
    .M_WLAST    (M_WLAST),
    .M_WREADY   (M_WREADY),
    .M_BVALID   (M_BVALID),
    .M_BREADY   (M_BREADY),
    .S0_AWVALID (S0_AWVALID),
    .S0_AWREADY (S0_AWREADY),
    .S0_WVALID  (S0_WVALID),
    .S0_WLAST   (S0_WLAST),
    .S0_WREADY  (S0_WREADY),
    .S0_BVALID  (S0_BVALID),
    .S0_BREADY  (S0_BREADY),
    .GRANT_IDX  (GRANT_IDX),
    .GRANT_VLD  (GRANT_VLD),
    .ERR_WLAST  (ERR_WLAST)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    int m;
    int len;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  int   beat;
  int   done_cnt;
  bit   exp_err;
  bit   toggle_wready;
  int   vectors;
  int   miscompares;

  int m_len  [4];
  int m_beat [4];
  int m_errb [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_master();
    for (int i = 0; i < 4; i++) begin
      M_AWLEN[4*i +: 4] = 4'(m_len[i]);
      M_WLAST[i] = (m_beat[i] == m_len[i]) || (m_beat[i] == m_errb[i]);
    end
  endtask

  // Scoreboard side: pops the expected transaction on the AW handshake and
  // checks routing, WLAST and burst length as the DUT moves through it.
  task automatic monitor();
    check("err_wlast", ERR_WLAST, exp_err);
    if (S0_AWVALID && S0_AWREADY) begin
      check("aw_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      beat = 0;
      check("aw_grant", GRANT_IDX, cur.m);
      check("aw_ready", M_AWREADY, 32'(1) << cur.m);
    end
    if (S0_WVALID && S0_WREADY) begin
      check("w_ready", M_WREADY, 32'(1) << cur.m);
      check("w_last", S0_WLAST, beat == cur.len);
      if (M_WLAST[cur.m] != (beat == cur.len)) exp_err = 1'b1;
      beat++;
    end
    if (S0_BVALID && S0_BREADY) begin
      check("b_route", M_BVALID, 32'(1) << cur.m);
      check("b_beats", beat, cur.len + 1);
      done_cnt++;
    end
  endtask

  task automatic step();
    logic [3:0] aw_hs_m;
    logic [3:0] w_hs_m;
    @(negedge ACLK);
    aw_hs_m = M_AWVALID & M_AWREADY;
    w_hs_m  = M_WVALID & M_WREADY;
    if (!ARESET) monitor();
    @(posedge ACLK);
    #1;
    M_AWVALID = M_AWVALID & ~aw_hs_m;
    for (int i = 0; i < 4; i++) begin
      if (w_hs_m[i]) begin
        if (m_beat[i] == m_len[i]) M_WVALID[i] = 1'b0;
        else                       m_beat[i]++;
      end
    end
    if (toggle_wready) S0_WREADY = ~S0_WREADY;
    drive_master();
  endtask

  task automatic clear_masters();
    M_AWVALID = '0;
    M_WVALID  = '0;
    for (int i = 0; i < 4; i++) begin
      m_len[i]  = 0;
      m_beat[i] = 0;
      m_errb[i] = -1;
    end
    drive_master();
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    clear_masters();
    step();
    ARESET = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  task automatic request(input int m, input int len, input int errb);
    m_len[m]     = len;
    m_beat[m]    = 0;
    m_errb[m]    = errb;
    M_AWVALID[m] = 1'b1;
    M_WVALID[m]  = 1'b1;
    exp_q.push_back('{m: m, len: len});
    drive_master();
  endtask

  task automatic run_txns(input int n, input int budget);
    int target;
    target = done_cnt + n;
    for (int c = 0; c < budget && done_cnt < target; c++) step();
    check("txn_done", done_cnt, target);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    done_cnt      = 0;
    beat          = 0;
    exp_err       = 1'b0;
    toggle_wready = 1'b0;
    cur           = '{m: 0, len: 0};
    ARESET        = 1'b1;
    M_BREADY      = 4'hF;
    S0_AWREADY    = 1'b1;
    S0_WREADY     = 1'b1;
    S0_BVALID     = 1'b1;
    M_AWLEN       = '0;
    M_WLAST       = '0;
    clear_masters();

    // 1: reset state, then master 2 with a 4-beat burst
    do_reset();
    #1;
    check("rst_grant_idx", GRANT_IDX, 0);
    check("rst_grant_vld", GRANT_VLD, 0);
    check("rst_err", ERR_WLAST, 0);
    check("rst_ptr", dut.u_rr.ptr_q, 0);
    check("idle_bvalid", M_BVALID, 0);
    check("idle_bready", S0_BREADY, 0);
    request(2, 3, -1);
    #1;
    check("aw_latency_idle", S0_AWVALID, 0);
    check("aw_latency_ready", M_AWREADY, 0);
    step();
    #1;
    check("aw_valid_next", S0_AWVALID, 1);
    check("aw_grant_idx", GRANT_IDX, 2);
    check("aw_grant_vld", GRANT_VLD, 1);
    run_txns(1, 20);
    check("t1_ptr", dut.u_rr.ptr_q, 3);

    // 2: all four masters requesting, single-beat bursts, order 0..3
    do_reset();
    for (int i = 0; i < 4; i++) request(i, 0, -1);
    run_txns(4, 60);
    check("t2_ptr", dut.u_rr.ptr_q, 0);
    check("t2_no_pending", M_AWVALID, 0);

    // 3: 16-beat burst with S0_WREADY toggling every cycle
    request(1, 15, -1);
    toggle_wready = 1'b1;
    run_txns(1, 100);
    toggle_wready = 1'b0;
    S0_WREADY     = 1'b1;
    check("t3_ptr", dut.u_rr.ptr_q, 2);
    check("t3_beat_hold", dut.beat_cnt_q, 15);

    // 4: early WLAST on beat 2 of 3 sets the sticky error
    do_reset();
    request(0, 2, 1);
    run_txns(1, 20);
    for (int c = 0; c < 3; c++) step();
    #1;
    check("t4_err_sticky", ERR_WLAST, 1);

    // 5: reset during W beat 1 of 4 aborts the transaction
    request(2, 3, -1);
    for (int c = 0; c < 20 && !(beat == 1 && S0_WVALID); c++) step();
    check("t5_reached_beat1", beat, 1);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    M_AWVALID = 4'b0010;
    #1;
    check("t5_state_idle", GRANT_VLD, 0);
    check("t5_wvalid", S0_WVALID, 0);
    check("t5_wready", M_WREADY, 0);
    check("t5_awvalid", S0_AWVALID, 0);
    check("t5_awready", M_AWREADY, 0);
    check("t5_bvalid", M_BVALID, 0);
    check("t5_err_clear", ERR_WLAST, 0);
    check("t5_ptr", dut.u_rr.ptr_q, 0);
    clear_masters();
    request(1, 1, -1);
    run_txns(1, 20);

    // 6: master 3 drives W two cycles before its AW
    m_len[3]    = 1;
    m_beat[3]   = 0;
    M_WVALID[3] = 1'b1;
    drive_master();
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t6_early_wready", M_WREADY[3], 0);
      check("t6_early_wvalid", S0_WVALID, 0);
      step();
    end
    M_AWVALID[3] = 1'b1;
    exp_q.push_back('{m: 3, len: 1});
    #1;
    check("t6_pre_aw_wready", M_WREADY[3], 0);
    run_txns(1, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
